led_fade_pwm: RTL

Downstream stage of the 8-bit running-light register. Consumes its LED pattern and drives the physical LEDs with PWM brightness. A lit bit shows at full brightness; a bit that turns off fades out linearly, giving a comet-trail effect. Runs on a fast clock (`clock`, e.g. 1 kHz divider output); `pattern_in` comes from the slow 1 Hz domain and is synchronised internally.

---
 rtl/led_fade_pwm.sv | 131 +++++++++++++
 1 files changed

// File: rtl/led_fade_pwm.sv
// led_fade_pwm: drives LEDs from a running-light pattern with PWM brightness.
// Lit pattern bits show at full duty; released bits fade out one level per fade step.
module led_fade_pwm #(
  parameter int unsigned NUM_LED  = 8,
  parameter int unsigned PWM_BITS = 4,
  parameter int unsigned FADE_DIV = 2
) (
  input  logic               clock,
  input  logic               sys_rst_n,
  input  logic               enable,
  input  logic [NUM_LED-1:0] pattern_in,
  output logic [NUM_LED-1:0] led_out,
  output logic               frame_start
);

  localparam int unsigned FC_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAXL     = '1;
  localparam logic [PWM_BITS-1:0] PWM_LAST = MAXL - PWM_BITS'(1);
  localparam logic [FC_W-1:0]     FC_LAST  = FC_W'(FADE_DIV - 1);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } run_state_t;

  run_state_t          state;
  run_state_t          state_next;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] pwm_next;
  logic [FC_W-1:0]     frame_cnt;
  logic [FC_W-1:0]     fc_next;
  logic                fs_next;
  logic                fade_step;
  logic [NUM_LED-1:0]  sync1;
  logic [NUM_LED-1:0]  sync2;
  logic [PWM_BITS-1:0] level [NUM_LED];

  // Two-flop synchroniser; keeps running while disabled.
  always_ff @(posedge clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pattern_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      pwm_cnt     <= '0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_next;
      pwm_cnt     <= pwm_next;
      frame_cnt   <= fc_next;
      frame_start <= fs_next;
    end
  end

  // ST_IDLE holds pwm_cnt at 0 for the first running cycle so that
  // frame_start marks it, both after reset release and after re-enable.
  always_comb begin
    state_next = state;
    pwm_next   = pwm_cnt;
    fc_next    = frame_cnt;
    fs_next    = 1'b0;
    fade_step  = 1'b0;
    if (!enable) begin
      state_next = ST_IDLE;
      pwm_next   = '0;
      fc_next    = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_next = ST_RUN;
          pwm_next   = '0;
          fc_next    = '0;
          fs_next    = 1'b1;
        end
        ST_RUN: begin
          if (pwm_cnt == PWM_LAST) begin
            pwm_next = '0;
            fs_next  = 1'b1;
            if (frame_cnt == FC_LAST) begin
              fc_next   = '0;
              fade_step = 1'b1;
            end else begin
              fc_next = frame_cnt + FC_W'(1);
            end
          end else begin
            pwm_next = pwm_cnt + PWM_BITS'(1);
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // A lit pattern bit overrides a coincident fade step.
  always_ff @(posedge clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int unsigned i = 0; i < NUM_LED; i++) begin
        level[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_LED; i++) begin
        if (!enable) begin
          level[i] <= '0;
        end else if (sync2[i]) begin
          level[i] <= MAXL;
        end else if (fade_step && (level[i] != '0)) begin
          level[i] <= level[i] - PWM_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led_out <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_LED; i++) begin
        led_out[i] <= enable && (level[i] > pwm_cnt);
      end
    end
  end

endmodule
